// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Owns the single write port of the 32x32 register file. Two sources share it:
//   - the in-order pipeline writeback (fixed timing, always wins);
//   - a long-latency auxiliary unit (mul/div/load) that hands over results with
//     a valid/ready handshake into a one-entry hold buffer.
//   A per-register busy scoreboard tracks outstanding aux ops and drives the
//   decode hazard. If an aux result waits too long, a registered pipe_stall
//   forces a free writeback slot.
//
// Optional feature (macro WB_ARB_CHECK_EN):
//   When defined, sb_err is a sticky protocol-error flag. It is set by an aux
//   capture to a non-busy register, or by an issue to an already-busy register
//   that is not being cleared that cycle. When undefined, sb_err is tied to 0.
//
// Handshake:
//   An aux result transfers on a cycle where aux_valid && aux_ready at posedge.
//   aux_ready is high only while the hold buffer is EMPTY. The source must keep
//   aux_valid/aux_wa/aux_wd stable until the transfer happens.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pipe_we/wa/wd         pipeline writeback request (priority source)
//   aux_valid/ready/wa/wd aux result handshake
//   iss_valid, iss_rd     long-latency op issue (sets busy)
//   chk_rs1/rs2/rd        decode-stage registers checked for hazard
//   hazard                decode must hold (combinational)
//   pipe_stall            registered stall request
//   rf_we/wa/wd           register file write port
//   busy_vec              scoreboard, bit 0 always 0
//   sb_err                sticky protocol error (see above)
//   state_dbg             hold-buffer FSM state (0 EMPTY, 1 HELD, 2 FORCE)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_wa,
   input  logic [31:0] pipe_wd,
   input  logic        aux_valid,
   output logic        aux_ready,
   input  logic [4:0]  aux_wa,
   input  logic [31:0] aux_wd,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  chk_rs1,
   input  logic [4:0]  chk_rs2,
   input  logic [4:0]  chk_rd,
   output logic        hazard,
   output logic        pipe_stall,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic [31:0] busy_vec,
   output logic        sb_err,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HELD  = 2'd1,
      FORCE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [4:0]          hold_wa;
   logic [31:0]         hold_wd;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [31:0]         busy, busy_nxt, set_mask, clr_mask;
   logic                capture, commit, sel_we;

   // Next-state logic for the hold buffer.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      commit    = 1'b0;
      case (state)
         EMPTY: begin
            if (aux_valid) begin
               capture   = 1'b1;
               state_nxt = HELD;
            end
         end
         HELD: begin
            if (!pipe_we) begin
               commit    = 1'b1;
               state_nxt = EMPTY;
            end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
               state_nxt = FORCE;
            end
         end
         FORCE: begin
            if (!pipe_we) begin
               commit    = 1'b1;
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Scoreboard update: set is applied after clear so that an issue to the
   // register being committed this cycle keeps it busy.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (iss_valid && (iss_rd != 5'd0)) set_mask = 32'd1 << iss_rd;
      if (commit)                        clr_mask = 32'd1 << hold_wa;
      busy_nxt = ((busy & ~clr_mask) | set_mask) & ~32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         wait_cnt   <= '0;
         pipe_stall <= 1'b0;
         busy       <= '0;
         hold_wa    <= '0;
         hold_wd    <= '0;
      end else begin
         state      <= state_nxt;
         // Registered so the stall is visible from the cycle after FORCE entry
         // and drops the cycle after the forced commit.
         pipe_stall <= (state_nxt == FORCE);
         busy       <= busy_nxt;
         if (capture) begin
            hold_wa <= aux_wa;
            hold_wd <= aux_wd;
         end
         if (commit)
            wait_cnt <= '0;
         else if ((state == HELD) && pipe_we)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Write port mux: pipeline first, then a pending aux entry, else idle zeros.
   always_comb begin
      sel_we = 1'b0;
      rf_wa  = '0;
      rf_wd  = '0;
      if (pipe_we) begin
         sel_we = 1'b1;
         rf_wa  = pipe_wa;
         rf_wd  = pipe_wd;
      end else if (state != EMPTY) begin
         sel_we = 1'b1;
         rf_wa  = hold_wa;
         rf_wd  = hold_wd;
      end
   end

   // x0 writes are dropped; no write goes out in a reset cycle.
   assign rf_we     = sel_we && (rf_wa != 5'd0) && rst_n;
   assign aux_ready = (state == EMPTY);
   assign hazard    = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];
   assign busy_vec  = busy;
   assign state_dbg = state;

`ifdef WB_ARB_CHECK_EN
   logic err_cap, err_iss, err_q;

   assign err_cap = capture && !busy[aux_wa];
   assign err_iss = iss_valid && (iss_rd != 5'd0) && busy[iss_rd] &&
                    !(commit && (hold_wa == iss_rd));

   always_ff @(posedge clk) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (err_cap || err_iss)
         err_q <= 1'b1;
   end

   assign sb_err = err_q;
`else
   assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed bench for wb_port_arbiter. Inputs change 1 ns after posedge; outputs
// are sampled 1 ns after that (combinational) or 1 ns after the next posedge
// (registered), never on the edge itself.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_we;
   logic [4:0]  pipe_wa;
   logic [31:0] pipe_wd;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_wa;
   logic [31:0] aux_wd;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  chk_rs1, chk_rs2, chk_rd;
   logic        hazard, pipe_stall, rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd, busy_vec;
   logic        sb_err;
   logic [1:0]  state_dbg;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   wb_port_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
      .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_wa(aux_wa), .aux_wd(aux_wd),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
      .hazard(hazard), .pipe_stall(pipe_stall),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .busy_vec(busy_vec), .sb_err(sb_err), .state_dbg(state_dbg)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      pipe_we   = 1'b0; pipe_wa = '0; pipe_wd = '0;
      aux_valid = 1'b0; aux_wa  = '0; aux_wd  = '0;
      iss_valid = 1'b0; iss_rd  = '0;
      chk_rs1   = '0;   chk_rs2 = '0; chk_rd  = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [4:0] rd);
      iss_valid = 1'b1; iss_rd = rd;
      tick();
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      do_reset();
      settle();
      n_cmp++; if (aux_ready !== 1'b1)    begin n_fail++; $display("FAIL rst_aux_ready got %0b want 1", aux_ready); end
      n_cmp++; if (pipe_stall !== 1'b0)   begin n_fail++; $display("FAIL rst_pipe_stall got %0b want 0", pipe_stall); end
      n_cmp++; if (busy_vec !== 32'h0)    begin n_fail++; $display("FAIL rst_busy got %h want 0", busy_vec); end
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== 38'h0) begin n_fail++; $display("FAIL rst_idle_port got we=%0b wa=%0d wd=%h want 0/0/0", rf_we, rf_wa, rf_wd); end
      n_cmp++; if (sb_err !== 1'b0)       begin n_fail++; $display("FAIL rst_sb_err got %0b want 0", sb_err); end
      n_cmp++; if (hazard !== 1'b0)       begin n_fail++; $display("FAIL rst_hazard got %0b want 0", hazard); end
   endtask

   task automatic test_aux_basic();
      issue(5'd5);
      n_cmp++; if (busy_vec !== 32'h0000_0020) begin n_fail++; $display("FAIL basic_busy_set got %h want 00000020", busy_vec); end
      aux_valid = 1'b1; aux_wa = 5'd5; aux_wd = 32'hDEAD;
      settle();
      n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL basic_no_write_before_capture got %0b want 0", rf_we); end
      tick();
      aux_valid = 1'b0;
      settle();
      n_cmp++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_held got %0b want 0", aux_ready); end
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'hDEAD}) begin n_fail++; $display("FAIL basic_commit got we=%0b wa=%0d wd=%h want 1/5/0000dead", rf_we, rf_wa, rf_wd); end
      tick();
      n_cmp++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL basic_busy_clear got %h want 0", busy_vec); end
      n_cmp++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got %0b want 1", aux_ready); end
   endtask

   task automatic test_x0_and_priority();
      pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h1111;
      settle();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h1111}) begin n_fail++; $display("FAIL pipe_write got we=%0b wa=%0d wd=%h want 1/3/00001111", rf_we, rf_wa, rf_wd); end
      pipe_wa = 5'd0; pipe_wd = 32'h1234;
      settle();
      n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pipe_x0_dropped got %0b want 0", rf_we); end
      pipe_we = 1'b0; pipe_wd = '0;
      aux_valid = 1'b1; aux_wa = 5'd0; aux_wd = 32'h55;
      tick();
      aux_valid = 1'b0;
      settle();
      n_cmp++; if (rf_we !== 1'b0 || aux_ready !== 1'b0) begin n_fail++; $display("FAIL aux_x0_commit got we=%0b ready=%0b want 0/0", rf_we, aux_ready); end
      tick();
      n_cmp++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL aux_x0_consumed got %0b want 1", aux_ready); end
   endtask

   task automatic test_force();
      issue(5'd6);
      aux_valid = 1'b1; aux_wa = 5'd6; aux_wd = 32'hBEEF;
      pipe_we = 1'b1; pipe_wa = 5'd1; pipe_wd = 32'hAAAA;
      tick();                       // capture edge
      aux_valid = 1'b0;
      settle();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd1, 32'hAAAA}) begin n_fail++; $display("FAIL force_pipe_priority got we=%0b wa=%0d wd=%h want 1/1/0000aaaa", rf_we, rf_wa, rf_wd); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL force_no_stall_early cycle %0d got %0b want 0", i, pipe_stall); end
      end
      tick();                       // 4th waiting cycle ends
      n_cmp++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL force_stall got %0b want 1", pipe_stall); end
      pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
      settle();
      n_cmp++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd6, 32'hBEEF}) begin n_fail++; $display("FAIL force_commit got we=%0b wa=%0d wd=%h want 1/6/0000beef", rf_we, rf_wa, rf_wd); end
      tick();
      n_cmp++; if (pipe_stall !== 1'b0 || aux_ready !== 1'b1 || busy_vec !== 32'h0) begin n_fail++; $display("FAIL force_release got stall=%0b ready=%0b busy=%h want 0/1/0", pipe_stall, aux_ready, busy_vec); end
   endtask

   task automatic test_hazard_set_wins();
      issue(5'd7);
      chk_rs2 = 5'd7; settle();
      n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_rs2 got %0b want 1", hazard); end
      chk_rs2 = 5'd3; chk_rs1 = 5'd7; settle();
      n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_rs1 got %0b want 1", hazard); end
      chk_rs1 = 5'd2; chk_rd = 5'd7; settle();
      n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_rd got %0b want 1", hazard); end
      chk_rd = 5'd4; settle();
      n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_none got %0b want 0", hazard); end
      aux_valid = 1'b1; aux_wa = 5'd7; aux_wd = 32'h77;
      tick();
      aux_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd7;
      settle();
      n_cmp++; if ({rf_we, rf_wa} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL setwins_commit got we=%0b wa=%0d want 1/7", rf_we, rf_wa); end
      tick();
      iss_valid = 1'b0; iss_rd = '0;
      n_cmp++; if (busy_vec !== 32'h0000_0080) begin n_fail++; $display("FAIL setwins_busy got %h want 00000080", busy_vec); end
      // drain the re-issued x7
      aux_valid = 1'b1; aux_wa = 5'd7; aux_wd = 32'h78;
      tick();
      aux_valid = 1'b0;
      tick();
      n_cmp++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL setwins_drain got %h want 0", busy_vec); end
      chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
   endtask

   task automatic test_reset_in_force();
      issue(5'd8);
      aux_valid = 1'b1; aux_wa = 5'd8; aux_wd = 32'h8888;
      pipe_we = 1'b1; pipe_wa = 5'd2; pipe_wd = 32'h2;
      tick();
      aux_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (pipe_stall !== 1'b1) begin n_fail++; $display("FAIL rif_stall got %0b want 1", pipe_stall); end
      pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
      rst_n = 1'b0;
      settle();
      n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rif_no_write got %0b want 0", rf_we); end
      tick();
      rst_n = 1'b1;
      settle();
      n_cmp++; if (aux_ready !== 1'b1 || pipe_stall !== 1'b0 || busy_vec !== 32'h0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL rif_after got ready=%0b stall=%0b busy=%h we=%0b want 1/0/0/0", aux_ready, pipe_stall, busy_vec, rf_we); end
   endtask

   task automatic test_sb_err();
      logic exp_err;
`ifdef WB_ARB_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      n_cmp++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sberr_clean got %0b want 0", sb_err); end
      aux_valid = 1'b1; aux_wa = 5'd9; aux_wd = 32'h9;
      tick();
      aux_valid = 1'b0;
      n_cmp++; if (sb_err !== exp_err) begin n_fail++; $display("FAIL sberr_set got %0b want %0b", sb_err, exp_err); end
      tick(); tick();
      n_cmp++; if (sb_err !== exp_err) begin n_fail++; $display("FAIL sberr_sticky got %0b want %0b", sb_err, exp_err); end
      do_reset();
      settle();
      n_cmp++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sberr_reset got %0b want 0", sb_err); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      // consecutive pipe writes, one per cycle
      for (int i = 0; i < 4; i++) begin
         pipe_we = 1'b1; pipe_wa = 5'(10 + i); pipe_wd = 32'hC000_0000 + 32'(i);
         exp_q.push_back(32'hC000_0000 + 32'(i));
         settle();
         got = exp_q.pop_front();
         n_cmp++; if (rf_we !== 1'b1 || rf_wd !== got) begin n_fail++; $display("FAIL b2b_pipe_%0d got we=%0b wd=%h want 1/%h", i, rf_we, rf_wd, got); end
         tick();
      end
      pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
      // two aux results offered back to back; second accepted after the commit cycle
      iss_valid = 1'b1; iss_rd = 5'd12; tick();
      iss_rd = 5'd13; tick();
      iss_valid = 1'b0; iss_rd = '0;
      aux_valid = 1'b1; aux_wa = 5'd12; aux_wd = 32'hA12;
      tick();                       // capture #1
      aux_wa = 5'd13; aux_wd = 32'hA13;
      settle();
      n_cmp++; if (aux_ready !== 1'b0 || rf_wa !== 5'd12 || rf_wd !== 32'hA12) begin n_fail++; $display("FAIL b2b_aux1 got ready=%0b wa=%0d wd=%h want 0/12/00000a12", aux_ready, rf_wa, rf_wd); end
      tick();                       // commit #1, no capture
      settle();
      n_cmp++; if (aux_ready !== 1'b1 || rf_we !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got ready=%0b we=%0b want 1/0", aux_ready, rf_we); end
      tick();                       // capture #2
      aux_valid = 1'b0;
      settle();
      n_cmp++; if (rf_we !== 1'b1 || rf_wa !== 5'd13 || rf_wd !== 32'hA13) begin n_fail++; $display("FAIL b2b_aux2 got we=%0b wa=%0d wd=%h want 1/13/00000a13", rf_we, rf_wa, rf_wd); end
      tick();
      n_cmp++; if (busy_vec !== 32'h0 || aux_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end got busy=%h ready=%0b want 0/1", busy_vec, aux_ready); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_aux_basic();
      test_x0_and_priority();
      test_force();
      test_hazard_set_wins();
      test_reset_in_force();
      test_sb_err();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
